posit_decoder_pipe: RTL and testbench

//  Parametrised, 2-stage pipelined posit decoder with valid/ready handshake; successor to the combinational 8-bit decoder.

---
 rtl/posit_dec_pkg.sv | 35 +++
 rtl/posit_run_detect.sv | 32 +++
 rtl/posit_decoder_pipe.sv | 159 +++++++++++++++
 tb/tb_posit_decoder_pipe.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_dec_pkg.sv
// ----------------------------------------------------------------------------
// posit_dec_pkg
// Shared helpers for the pipelined posit decoder:
//   calc_kw / calc_fs / calc_ew : derived widths (signed regime, fraction,
//                                 exponent output) from posit width N and ES
//   posit_flags_t               : per-word sign/zero/NaR flags carried down
//                                 the pipeline
//   NAR_PATTERN_32 / ZERO_PATTERN_32 : special encodings, MSB-aligned to 32
//                                 bits; slice the top N bits for an N-bit posit
// ----------------------------------------------------------------------------
package posit_dec_pkg;

    function automatic int calc_kw(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int calc_fs(input int n, input int es);
        return n - es - 3;
    endfunction

    // ES=0 still gets a one-bit exponent port, tied to zero.
    function automatic int calc_ew(input int es);
        return (es > 0) ? es : 1;
    endfunction

    typedef struct packed {
        logic sign;
        logic zero;
        logic nar;
    } posit_flags_t;

    localparam logic [31:0] NAR_PATTERN_32  = 32'h8000_0000;
    localparam logic [31:0] ZERO_PATTERN_32 = 32'h0000_0000;

endpackage

// File: rtl/posit_run_detect.sv
// ----------------------------------------------------------------------------
// posit_run_detect
// Combinational leading-run detector for the regime field.
//   bits    : W-bit posit magnitude body (MSB is the regime's first bit r0)
//   run_len : number of leading bits equal to bits[W-1] (1..W)
//   term    : 1 when the run ends on an opposite bit inside the word,
//             0 when the run reaches the LSB
// ----------------------------------------------------------------------------
module posit_run_detect #(
    parameter  int W  = 7,
    localparam int MW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits,
    output logic [MW-1:0] run_len,
    output logic          term
);

    always_comb begin
        run_len = '0;
        term    = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!term) begin
                if (bits[i] == bits[W-1]) begin
                    run_len = run_len + MW'(1);
                end else begin
                    term = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/posit_decoder_pipe.sv
// ----------------------------------------------------------------------------
// posit_decoder_pipe
// Two-stage pipelined posit decoder with valid/ready handshake.
//   S1 registers sign, two's-complement magnitude and zero/NaR flags.
//   S2 runs the regime detector and registers k, exponent and fraction.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake, in_posit is the raw N-bit posit
//   out_valid/out_ready   : output handshake
//   sign_out, k_out       : sign bit, signed regime value (KW bits)
//   exp_out, frac_out     : exponent (max(ES,1) bits), fraction (FS bits,
//                           MSB-aligned, zero-padded right)
//   zero_out, nar_out     : special-value flags
//   scale_out             : k*2^ES + exp, signed KW+ES bits; present only
//                           when POSIT_DEC_SCALE_EN is defined
// ----------------------------------------------------------------------------
module posit_decoder_pipe
    import posit_dec_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int ES = 1,
    localparam int FS = calc_fs(N, ES),
    localparam int KW = calc_kw(N),
    localparam int EW = calc_ew(ES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_posit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          sign_out,
    output logic [KW-1:0] k_out,
    output logic [EW-1:0] exp_out,
    output logic [FS-1:0] frac_out,
    output logic          zero_out,
    output logic          nar_out
`ifdef POSIT_DEC_SCALE_EN
    ,
    output logic [KW+ES-1:0] scale_out
`endif
);

    localparam int W  = N - 1;
    localparam int MW = $clog2(N);
    localparam logic [N-1:0] NAR_WORD  = NAR_PATTERN_32[31 -: N];
    localparam logic [N-1:0] ZERO_WORD = ZERO_PATTERN_32[N-1:0];

    logic         s1_valid;
    posit_flags_t s1_flags;
    logic [W-1:0] s1_mag;
    logic         s2_free;

    logic [W-1:0] in_body;
    logic [W-1:0] mag_c;

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;

    assign in_body = in_posit[N-2:0];
    assign mag_c   = in_posit[N-1] ? -in_body : in_body;

    // S2 decode
    logic [MW-1:0]        run_len;
    logic                 run_term;
    logic [MW:0]          consumed;
    logic [MW:0]          shamt;
    logic [W-3:0]         rest;
    logic [EW-1:0]        exp_c;
    logic signed [KW-1:0] m_s;
    logic signed [KW-1:0] k_c;
    logic [EW-1:0]        exp_d;
    logic [FS-1:0]        frac_d;

    posit_run_detect #(.W(W)) u_run_detect (
        .bits    (s1_mag),
        .run_len (run_len),
        .term    (run_term)
    );

    // The regime always eats at least two bits (run of >=1 plus terminator,
    // or a full-width run), so only the low W-2 bits can ever survive; shift
    // those by the remaining amount to left-align exponent and fraction.
    assign consumed = {1'b0, run_len} + {{MW{1'b0}}, run_term};
    assign shamt    = consumed - (MW + 1)'(2);
    assign rest     = s1_mag[W-3:0] << shamt;

    if (ES > 0) begin : g_exp
        assign exp_c = rest[W-3 -: ES];
    end else begin : g_no_exp
        assign exp_c = 1'b0;
    end

    always_comb begin
        m_s = KW'(run_len);
        if (s1_flags.zero || s1_flags.nar) begin
            k_c    = '0;
            exp_d  = '0;
            frac_d = '0;
        end else begin
            k_c    = s1_mag[W-1] ? m_s - KW'(1) : -m_s;
            exp_d  = exp_c;
            frac_d = rest[FS-1:0];
        end
    end

`ifdef POSIT_DEC_SCALE_EN
    logic [KW+ES-1:0] scale_c;
    if (ES > 0) begin : g_scale_exp
        assign scale_c = {k_c, exp_d};
    end else begin : g_scale_k
        assign scale_c = k_c;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_flags  <= '0;
            s1_mag    <= '0;
            out_valid <= 1'b0;
            sign_out  <= 1'b0;
            k_out     <= '0;
            exp_out   <= '0;
            frac_out  <= '0;
            zero_out  <= 1'b0;
            nar_out   <= 1'b0;
`ifdef POSIT_DEC_SCALE_EN
            scale_out <= '0;
`endif
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_flags.sign <= in_posit[N-1];
                    s1_flags.zero <= (in_posit == ZERO_WORD);
                    s1_flags.nar  <= (in_posit == NAR_WORD);
                    s1_mag        <= mag_c;
                end
            end
            if (s2_free) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    sign_out  <= s1_flags.sign;
                    k_out     <= k_c;
                    exp_out   <= exp_d;
                    frac_out  <= frac_d;
                    zero_out  <= s1_flags.zero;
                    nar_out   <= s1_flags.nar;
`ifdef POSIT_DEC_SCALE_EN
                    scale_out <= scale_c;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_posit_decoder_pipe.sv
// ----------------------------------------------------------------------------
// tb_posit_decoder_pipe
// Two decoder instances: N=8/ES=1 for directed, stall and reset scenarios,
// N=16/ES=2 for a random stream. A scoreboard per instance records every
// accepted word and decodes it with an arithmetic reference model when the
// matching output transfer happens. scale_out is checked when
// POSIT_DEC_SCALE_EN is defined.
// ----------------------------------------------------------------------------
module tb_posit_decoder_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input longint got, input longint want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Reference decode: walk the regime run on the integer magnitude, then
    // peel exponent and fraction off the remaining bit count.
    function automatic void ref_dec(input int n, input int es, input longint p,
                                    output longint sgn, output longint k,
                                    output longint e, output longint f,
                                    output longint z, output longint nr,
                                    output longint sc);
        longint mask_n = (longint'(1) << n) - 1;
        int     w      = n - 1;
        int     fs     = n - es - 3;
        longint x, rest;
        longint r0;
        int     m, rem, fb;
        sgn = (p >> (n - 1)) & 1;
        z   = (p == 0) ? 1 : 0;
        nr  = (p == (longint'(1) << (n - 1))) ? 1 : 0;
        k = 0; e = 0; f = 0; sc = 0;
        if (z == 1 || nr == 1) return;
        x  = (sgn == 1) ? ((-p) & mask_n) : p;
        x  = x & ((longint'(1) << w) - 1);
        r0 = (x >> (w - 1)) & 1;
        m  = 0;
        while (m < w && ((x >> (w - 1 - m)) & 1) == r0) m++;
        k   = (r0 == 1) ? longint'(m - 1) : -longint'(m);
        rem = w - m - 1;
        if (rem < 0) rem = 0;
        rest = x & ((longint'(1) << rem) - 1);
        if (rem >= es) e = rest >> (rem - es);
        else           e = rest << (es - rem);
        fb = rem - es;
        if (fb > 0) f = (rest & ((longint'(1) << fb) - 1)) << (fs - fb);
        sc = k * (longint'(1) << es) + e;
    endfunction

    // N=8, ES=1: KW=4, EW=1, FS=4
    logic       iv8, ir8, ov8, or8, s8, z8, n8;
    logic [7:0] ip8;
    logic [3:0] k8;
    logic [0:0] e8;
    logic [3:0] f8;
`ifdef POSIT_DEC_SCALE_EN
    logic [4:0] sc8;
`endif

    posit_decoder_pipe #(.N(8), .ES(1)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .in_posit  (ip8),
        .out_valid (ov8),
        .out_ready (or8),
        .sign_out  (s8),
        .k_out     (k8),
        .exp_out   (e8),
        .frac_out  (f8),
        .zero_out  (z8),
        .nar_out   (n8)
`ifdef POSIT_DEC_SCALE_EN
        ,
        .scale_out (sc8)
`endif
    );

    // N=16, ES=2: KW=5, EW=2, FS=11
    logic        iv16, ir16, ov16, or16, s16, z16, n16;
    logic [15:0] ip16;
    logic [4:0]  k16;
    logic [1:0]  e16;
    logic [10:0] f16;
`ifdef POSIT_DEC_SCALE_EN
    logic [6:0]  sc16;
`endif

    posit_decoder_pipe #(.N(16), .ES(2)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .in_posit  (ip16),
        .out_valid (ov16),
        .out_ready (or16),
        .sign_out  (s16),
        .k_out     (k16),
        .exp_out   (e16),
        .frac_out  (f16),
        .zero_out  (z16),
        .nar_out   (n16)
`ifdef POSIT_DEC_SCALE_EN
        ,
        .scale_out (sc16)
`endif
    );

    logic [7:0]  q8[$];
    logic [15:0] q16[$];

    always @(negedge clk) begin : sb8
        longint xs, xk, xe, xf, xz, xn, xsc;
        logic [7:0] p;
        if (rst) begin
            q8.delete();
        end else begin
            if (ov8 && or8) begin
                check_eq("sb8_pending", (q8.size() > 0) ? 1 : 0, 1);
                if (q8.size() > 0) begin
                    p = q8.pop_front();
                    ref_dec(8, 1, longint'(p), xs, xk, xe, xf, xz, xn, xsc);
                    check_eq("sb8_sign", s8, xs);
                    check_eq("sb8_k", $signed(k8), xk);
                    check_eq("sb8_exp", e8, xe);
                    check_eq("sb8_frac", f8, xf);
                    check_eq("sb8_zero", z8, xz);
                    check_eq("sb8_nar", n8, xn);
`ifdef POSIT_DEC_SCALE_EN
                    check_eq("sb8_scale", $signed(sc8), xsc);
`endif
                end
            end
            if (iv8 && ir8) q8.push_back(ip8);
        end
    end

    always @(negedge clk) begin : sb16
        longint xs, xk, xe, xf, xz, xn, xsc;
        logic [15:0] p;
        if (rst) begin
            q16.delete();
        end else begin
            if (ov16 && or16) begin
                check_eq("sb16_pending", (q16.size() > 0) ? 1 : 0, 1);
                if (q16.size() > 0) begin
                    p = q16.pop_front();
                    ref_dec(16, 2, longint'(p), xs, xk, xe, xf, xz, xn, xsc);
                    check_eq("sb16_sign", s16, xs);
                    check_eq("sb16_k", $signed(k16), xk);
                    check_eq("sb16_exp", e16, xe);
                    check_eq("sb16_frac", f16, xf);
                    check_eq("sb16_zero", z16, xz);
                    check_eq("sb16_nar", n16, xn);
`ifdef POSIT_DEC_SCALE_EN
                    check_eq("sb16_scale", $signed(sc16), xsc);
`endif
                end
            end
            if (iv16 && ir16) q16.push_back(ip16);
        end
    end

    // Single word with out_ready high: checks 2-cycle latency and fields.
    task automatic direct8(input logic [7:0] p, input int xs, input int xk,
                           input int xe, input int xf, input int xz, input int xn);
        iv8 = 1'b1; ip8 = p; or8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        check_eq($sformatf("d%02h_lat1", p), ov8, 0);
        @(posedge clk); #1;
        check_eq($sformatf("d%02h_lat2", p), ov8, 1);
        check_eq($sformatf("d%02h_sign", p), s8, xs);
        check_eq($sformatf("d%02h_k", p), $signed(k8), xk);
        check_eq($sformatf("d%02h_exp", p), e8, xe);
        check_eq($sformatf("d%02h_frac", p), f8, xf);
        check_eq($sformatf("d%02h_zero", p), z8, xz);
        check_eq($sformatf("d%02h_nar", p), n8, xn);
    endtask

    function automatic logic [15:0] pick16();
        int r = $urandom_range(0, 11);
        case (r)
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7FFF;
            3: return 16'h0001;
            4: return 16'hFFFF;
            5: return 16'h8001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin : main
        int seen;
        rst = 1'b1;
        iv8 = 0; ip8 = '0; or8 = 0;
        iv16 = 0; ip16 = '0; or16 = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", ov8, 0);
        check_eq("rst_k", k8, 0);
        check_eq("rst_frac", f8, 0);
        check_eq("rst_sign", s8, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_in_ready", ir8, 1);
        check_eq("rst_out_valid2", ov8, 0);

        // Directed decodes: value, sign, k, exp, frac, zero, nar
        direct8(8'h40, 0, 0, 0, 4'b0000, 0, 0);
        direct8(8'h50, 0, 0, 1, 4'b0000, 0, 0);
        direct8(8'hC0, 1, 0, 0, 4'b0000, 0, 0);
        direct8(8'h00, 0, 0, 0, 4'b0000, 1, 0);
        direct8(8'h80, 1, 0, 0, 4'b0000, 0, 1);
        direct8(8'h7F, 0, 6, 0, 4'b0000, 0, 0);
        direct8(8'h01, 0, -6, 0, 4'b0000, 0, 0);
        direct8(8'h33, 0, -1, 1, 4'b0011, 0, 0);
        direct8(8'hFF, 1, -6, 0, 4'b0000, 0, 0);
        @(posedge clk); #1;

        // Stall: three words back to back with the consumer blocked.
        or8 = 1'b0; iv8 = 1'b1; ip8 = 8'h40;
        @(posedge clk); #1;
        ip8 = 8'h50;
        check_eq("stall_rdy_after1", ir8, 1);
        @(posedge clk); #1;
        ip8 = 8'h7F;
        check_eq("stall_rdy_after2", ir8, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq($sformatf("stall_hold%0d_rdy", i), ir8, 0);
            check_eq($sformatf("stall_hold%0d_valid", i), ov8, 1);
            check_eq($sformatf("stall_hold%0d_exp", i), e8, 0);
            check_eq($sformatf("stall_hold%0d_k", i), $signed(k8), 0);
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        check_eq("stall_out2_exp", e8, 1);
        check_eq("stall_out2_valid", ov8, 1);
        @(posedge clk); #1;
        check_eq("stall_out3_k", $signed(k8), 6);
        check_eq("stall_out3_valid", ov8, 1);
        @(posedge clk); #1;
        check_eq("stall_empty", ov8, 0);

        // Reset with both stages full.
        or8 = 1'b0; iv8 = 1'b1; ip8 = 8'hC0;
        @(posedge clk); #1;
        ip8 = 8'h7F;
        @(posedge clk); #1;
        iv8 = 1'b0;
        check_eq("pre_rst_valid", ov8, 1);
        check_eq("pre_rst_sign", s8, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midrst_valid", ov8, 0);
        check_eq("midrst_sign", s8, 0);
        check_eq("midrst_k", k8, 0);
        check_eq("midrst_exp", e8, 0);
        check_eq("midrst_in_ready", ir8, 1);
        or8 = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ov8) seen++;
        end
        check_eq("midrst_no_emit", seen, 0);

        // Random streams on both instances.
        for (int c = 0; c < 3000; c++) begin
            iv8  = ($urandom_range(0, 3) != 0);
            ip8  = 8'($urandom);
            or8  = ($urandom_range(0, 3) != 0);
            iv16 = ($urandom_range(0, 3) != 0);
            ip16 = pick16();
            or16 = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        iv8 = 0; iv16 = 0; or8 = 1; or16 = 1;
        for (int c = 0; c < 20; c++) begin
            if (q8.size() == 0 && q16.size() == 0 && !ov8 && !ov16) break;
            @(posedge clk); #1;
        end
        check_eq("drain8", q8.size(), 0);
        check_eq("drain16", q16.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
